// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - line-fill bus between the instruction cache and backing memory
interface icache_direct_mapped_if;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        MEM_ERR;

  // Cache side issues fill requests and consumes beats.
  modport master (
    output MEM_REQ, MEM_ADDR,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA, MEM_ERR
  );

  // Memory side grants requests and returns beats.
  modport slave (
    input  MEM_REQ, MEM_ADDR,
    output MEM_GNT, MEM_RVALID, MEM_RDATA, MEM_ERR
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with line refill
module icache_direct_mapped #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [63:0]             PC,
  input  logic                    FLUSH,
  output logic                    icache_r,
  output logic [31:0]             instruction,
  output logic                    icache_fault,
  icache_direct_mapped_if.master  mem
);

  localparam int WW   = $clog2(WORDS_PER_LINE);
  localparam int OFF  = WW + 2;
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 64 - OFF - IDXW;
  localparam logic [WW-1:0] LAST_BEAT = WW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                state_q, state_d;
  logic [31:0]           data_q [LINES*WORDS_PER_LINE];
  logic [TAGW-1:0]       tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  logic                  fault_v_q;
  logic [63-OFF:0]       fault_line_q;
  logic                  poison_q;
  logic [WW-1:0]         beat_q;
  logic                  mem_req_q;
  logic [63:0]           fill_addr_q;

  logic                  miss_start, fill_enter, beat_wr, fill_done, fill_err;

  logic [IDXW-1:0]       pc_idx;
  logic [WW-1:0]         pc_word;
  logic [TAGW-1:0]       pc_tag;
  logic [63-OFF:0]       pc_line;
  logic [IDXW-1:0]       fill_idx;
  logic                  unused_pc_bits;

  assign pc_word  = PC[OFF-1:2];
  assign pc_idx   = PC[OFF+IDXW-1:OFF];
  assign pc_tag   = PC[63:OFF+IDXW];
  assign pc_line  = PC[63:OFF];
  assign fill_idx = fill_addr_q[OFF+IDXW-1:OFF];
  assign unused_pc_bits = ^PC[1:0];

  // A faulting line masks any hit so fetch sees the error rather than stale data.
  assign icache_fault = fault_v_q && (pc_line == fault_line_q);
  assign icache_r     = (state_q == IDLE) && valid_q[pc_idx] &&
                        (tag_q[pc_idx] == pc_tag) && !icache_fault;
  assign instruction  = data_q[{pc_idx, pc_word}];

  assign mem.MEM_REQ  = mem_req_q;
  assign mem.MEM_ADDR = fill_addr_q;

  // Next-state and fill control strobes.
  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    fill_enter = 1'b0;
    beat_wr    = 1'b0;
    fill_done  = 1'b0;
    fill_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!icache_r && !icache_fault && !FLUSH) begin
          miss_start = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem.MEM_GNT) begin
          fill_enter = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem.MEM_RVALID) begin
          if (mem.MEM_ERR) begin
            fill_err = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_wr = 1'b1;
            if (beat_q == LAST_BEAT) begin
              fill_done = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Fill request, captured line address and beat counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_req_q   <= 1'b0;
      fill_addr_q <= '0;
      beat_q      <= '0;
    end else begin
      mem_req_q <= (state_d == REQ);
      if (miss_start) fill_addr_q <= {PC[63:OFF], {OFF{1'b0}}};
      if (fill_enter)   beat_q <= '0;
      else if (beat_wr) beat_q <= beat_q + 1'b1;
    end
  end

  // Valid bits, poison and fault tracking; FLUSH is applied last so it always wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q      <= '0;
      fault_v_q    <= 1'b0;
      fault_line_q <= '0;
      poison_q     <= 1'b0;
    end else begin
      if (fill_enter) valid_q[fill_idx] <= 1'b0;
      if (fill_done && !poison_q) valid_q[fill_idx] <= 1'b1;
      if (FLUSH) valid_q <= '0;

      if (state_d == IDLE) poison_q <= 1'b0;
      else if (FLUSH)      poison_q <= 1'b1;

      if (miss_start || FLUSH) fault_v_q <= 1'b0;
      if (fill_err) begin
        fault_v_q    <= 1'b1;
        fault_line_q <= fill_addr_q[63:OFF];
      end
    end
  end

  // Data and tag arrays; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge CLK) begin
    if (beat_wr)   data_q[{fill_idx, beat_q}] <= mem.MEM_RDATA;
    if (fill_done) tag_q[fill_idx] <= fill_addr_q[63:OFF+IDXW];
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - randomized self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;
  localparam int LINES = 64;
  localparam int WPL   = 4;
  localparam longint unsigned LB = WPL * 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] PC;
  logic        FLUSH;
  logic        icache_r;
  logic [31:0] instruction;
  logic        icache_fault;

  icache_direct_mapped_if mem_if();

  icache_direct_mapped #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .FLUSH(FLUSH),
    .icache_r(icache_r), .instruction(instruction), .icache_fault(icache_fault),
    .mem(mem_if)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  bit          m_valid [LINES];
  logic [63:0] m_tag   [LINES];
  bit          m_fault_v;
  logic [63:0] m_fault_line;
  logic [63:0] bases [3] = '{64'h0, 64'h400, 64'h0000_0100_0000_0400};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a / LB;
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a / LB) % LINES);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] a);
    return a / (LB * LINES);
  endfunction

  function automatic logic [31:0] memword(input logic [63:0] a);
    logic [63:0] w;
    logic [63:0] v;
    w = a / 4;
    v = 64'h13 + ((w % 4096) << 20) + ((w % 32) << 7);
    v = v ^ (((a >> 14) % 65536) << 16);
    return v[31:0];
  endfunction

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_fault_v = 1'b0;
  endtask

  task automatic fill_checks(input bit aborted);
    check_eq("fill_hit", 64'(icache_r), 64'd0);
    check_eq("fill_req", 64'(mem_if.MEM_REQ), 64'd0);
    if (aborted) check_eq("abort_fault", 64'(icache_fault), 64'd1);
  endtask

  task automatic do_reset();
    RESET = 1'b1; PC = '0; FLUSH = 1'b0;
    mem_if.MEM_GNT = 1'b0; mem_if.MEM_RVALID = 1'b0;
    mem_if.MEM_RDATA = '0; mem_if.MEM_ERR = 1'b0;
    model_flush();
    @(negedge CLK);
    check_eq("rst_hit",   64'(icache_r), 64'd0);
    check_eq("rst_fault", 64'(icache_fault), 64'd0);
    check_eq("rst_req",   64'(mem_if.MEM_REQ), 64'd0);
    check_eq("rst_addr",  mem_if.MEM_ADDR, 64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // One fetch at pc starting in an idle cycle; returns in the first idle cycle afterwards.
  task automatic do_fetch(input logic [63:0] pc, input int gnt_wait, input int gaps,
                          input int err_beat, input int flush_beat, input logic [63:0] alt_pc,
                          input bit flush_first, input bit stray);
    bit          exp_hit, exp_fault, poisoned, aborted;
    logic [63:0] laddr;
    int          li, ng;
    li = idx_of(pc);
    laddr = line_of(pc) * LB;
    poisoned = 1'b0;
    aborted = 1'b0;
    PC = pc;
    FLUSH = flush_first;
    mem_if.MEM_RVALID = stray;
    mem_if.MEM_RDATA = 32'hBAD0_0BAD;
    exp_fault = m_fault_v && (line_of(pc) == m_fault_line);
    exp_hit = m_valid[li] && (m_tag[li] == tag_of(pc)) && !exp_fault;
    @(negedge CLK);
    check_eq("hit",      64'(icache_r), 64'(exp_hit));
    check_eq("fault",    64'(icache_fault), 64'(exp_fault));
    check_eq("idle_req", 64'(mem_if.MEM_REQ), 64'd0);
    if (exp_hit) check_eq("insn", 64'(instruction), 64'(memword(pc)));
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    mem_if.MEM_RVALID = 1'b0;
    if (flush_first) begin
      model_flush();
      exp_hit = 1'b0;
      exp_fault = 1'b0;
      @(negedge CLK);
      check_eq("flush_hit",   64'(icache_r), 64'd0);
      check_eq("flush_fault", 64'(icache_fault), 64'd0);
      check_eq("flush_noreq", 64'(mem_if.MEM_REQ), 64'd0);
      @(posedge CLK); #1;
    end
    if (exp_hit || exp_fault) begin
      @(negedge CLK);
      check_eq("no_req", 64'(mem_if.MEM_REQ), 64'd0);
      @(posedge CLK); #1;
      return;
    end
    m_fault_v = 1'b0;
    if (alt_pc != pc) PC = alt_pc;
    for (int c = 0; c <= gnt_wait; c++) begin
      mem_if.MEM_GNT = (c == gnt_wait);
      @(negedge CLK);
      check_eq("req",     64'(mem_if.MEM_REQ), 64'd1);
      check_eq("addr",    mem_if.MEM_ADDR, laddr);
      check_eq("req_hit", 64'(icache_r), 64'd0);
      @(posedge CLK); #1;
    end
    mem_if.MEM_GNT = 1'b0;
    m_valid[li] = 1'b0;
    for (int b = 0; b < WPL; b++) begin
      ng = (gaps < 0) ? int'($urandom_range(0, 2)) : gaps;
      for (int g = 0; g < ng; g++) begin
        @(negedge CLK);
        fill_checks(aborted);
        @(posedge CLK); #1;
      end
      mem_if.MEM_RVALID = 1'b1;
      mem_if.MEM_RDATA = aborted ? 32'hDEAD_BEEF : memword(laddr + 64'(4 * b));
      mem_if.MEM_ERR = (b == err_beat);
      FLUSH = (b == flush_beat);
      @(negedge CLK);
      fill_checks(aborted);
      @(posedge CLK); #1;
      mem_if.MEM_RVALID = 1'b0;
      mem_if.MEM_ERR = 1'b0;
      FLUSH = 1'b0;
      if (b == flush_beat) begin
        model_flush();
        poisoned = 1'b1;
      end
      if (b == err_beat) begin
        aborted = 1'b1;
        m_fault_v = 1'b1;
        m_fault_line = line_of(pc);
      end
    end
    if (!aborted && !poisoned) begin
      m_valid[li] = 1'b1;
      m_tag[li] = tag_of(pc);
    end
  endtask

  initial begin
    logic [63:0] pc, alt;
    int          eb, fb;
    do_reset();

    // cold miss, zero-wait fill, then hits
    do_fetch(64'h0, 0, 0, -1, -1, 64'h0, 0, 0);
    do_fetch(64'h0, 0, 0, -1, -1, 64'h0, 0, 0);
    do_fetch(64'h8, 0, 0, -1, -1, 64'h8, 0, 0);
    check_eq("cold_insn", 64'(instruction), 64'h0020_0113);

    // conflict on index 0
    do_fetch(64'h400, 0, 0, -1, -1, 64'h400, 0, 0);
    do_fetch(64'h0, 0, 0, -1, -1, 64'h0, 0, 0);

    // flush on second beat poisons the line
    do_fetch(64'h40, 0, 0, -1, 1, 64'h40, 0, 0);
    do_fetch(64'h40, 0, 0, -1, -1, 64'h40, 0, 0);
    do_fetch(64'h0, 0, 0, -1, -1, 64'h0, 0, 0);

    // bus error on beat 1, fault cleared by another miss, then by FLUSH
    do_fetch(64'h80, 0, 0, 1, -1, 64'h80, 0, 0);
    do_fetch(64'h84, 0, 0, -1, -1, 64'h84, 0, 0);
    do_fetch(64'hC0, 0, 0, -1, -1, 64'hC0, 0, 0);
    do_fetch(64'h84, 0, 0, 2, -1, 64'h84, 0, 0);
    do_fetch(64'h84, 0, 0, -1, -1, 64'h84, 1, 0);

    // stalled grant, gapped beats, PC moved during the fill
    do_fetch(64'h100, 3, 1, -1, -1, 64'h200, 0, 0);
    do_fetch(64'h200, 0, 0, -1, -1, 64'h200, 0, 0);
    do_fetch(64'h104, 0, 0, -1, -1, 64'h104, 0, 0);

    // asynchronous reset after two beats of a fill
    PC = 64'h1C0;
    @(posedge CLK); #1;
    mem_if.MEM_GNT = 1'b1;
    @(posedge CLK); #1;
    mem_if.MEM_GNT = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_if.MEM_RVALID = 1'b1;
      mem_if.MEM_RDATA = memword(64'h1C0 + 64'(4 * b));
      @(posedge CLK); #1;
    end
    mem_if.MEM_RVALID = 1'b0;
    check_eq("pre_rst_addr", mem_if.MEM_ADDR, 64'h1C0);
    #2 RESET = 1'b1;
    #1;
    check_eq("arst_req",   64'(mem_if.MEM_REQ), 64'd0);
    check_eq("arst_addr",  mem_if.MEM_ADDR, 64'd0);
    check_eq("arst_hit",   64'(icache_r), 64'd0);
    check_eq("arst_fault", 64'(icache_fault), 64'd0);
    model_flush();
    @(posedge CLK); #1;
    RESET = 1'b0;
    do_fetch(64'h1C0, 0, 0, -1, -1, 64'h1C0, 0, 1);
    for (int k = 0; k < WPL; k++)
      do_fetch(64'h1C0 + 64'(4 * k), 0, 0, -1, -1, 64'h1C0 + 64'(4 * k), 0, 0);

    // randomized traffic over a small set of conflicting lines
    for (int n = 0; n < 200; n++) begin
      pc = bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 7)) * LB + 64'($urandom_range(0, 3)) * 4;
      eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
      fb = (eb < 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
      alt = pc;
      if (eb < 0 && $urandom_range(0, 4) == 0)
        alt = bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 7)) * LB;
      do_fetch(pc, int'($urandom_range(0, 2)), -1, eb, fb, alt,
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache_direct_mapped.md
# icache_direct_mapped

Direct-mapped, read-only instruction cache that sits directly upstream of the fetch stage. It answers the fetch stage's PC lookup combinationally (hit flag plus 32-bit instruction in the same cycle) and refills missing lines from a backing memory through a request/grant plus beat-stream interface. It supports a whole-cache invalidate (fence.i) and reports fetch access faults returned by memory.

## Interface
- LINES, 64: number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  64  fetch address; bits [1:0] ignored.
- FLUSH  in  1  invalidate all lines (fence.i); one-cycle pulse.
- icache_r  out  1  combinational hit: instruction is valid this cycle.
- instruction  out  32  combinational word at PC; don't-care when icache_r=0.
- icache_fault  out  1  combinational: PC lies in the line whose last fill returned an error.
- MEM_REQ  out  1  registered line-fill request.
- MEM_ADDR  out  64  registered line-aligned fill address.
- MEM_GNT  in  1  memory accepts the request this cycle.
- MEM_RVALID  in  1  one fill beat on MEM_RDATA.
- MEM_RDATA  in  32  fill data, word 0 first, ascending.
- MEM_ERR  in  1  qualifies a beat as a bus error.

## Operation
- Address split: OFF = log2(WORDS_PER_LINE)+2 bits [OFF-1:0]; IDX = log2(LINES) bits [OFF+IDX-1:OFF]; TAG = remaining upper bits. Defaults: word [3:2], index [9:4], tag [63:10].
- Storage: data array LINES×WORDS_PER_LINE×32 with asynchronous read; tag array; per-line valid bit. A registered-read RAM is not permitted, because fetch latches instruction on the same edge.
- icache_r = (state==IDLE) && valid[idx] && tag[idx]==PC tag && !icache_fault.
- FSM states: IDLE, REQ, FILL.
  - IDLE: if !icache_r && !icache_fault && !FLUSH, latch fill_addr = {PC[63:OFF], OFF'b0} and go to REQ.
  - REQ: MEM_REQ=1, MEM_ADDR=fill_addr. On MEM_GNT go to FILL with beat counter = 0.
  - FILL: each MEM_RVALID writes MEM_RDATA to word[beat] of the line at fill_addr's index, then increments beat. On the last beat (beat==WORDS_PER_LINE-1) write the tag, set valid (unless the line is poisoned, below), and go to IDLE.
- Line invalidated at entry to FILL, so partial data is never hit.
- PC changes during REQ/FILL are ignored; the captured line fill always completes.
- MEM_ERR on any beat: abort to IDLE and leave the line invalid. Set fault_v=1, fault_line=fill_addr[63:OFF]. Remaining beats of that burst (the memory still sends them) are ignored.
- icache_fault = fault_v && PC[63:OFF]==fault_line. While it is asserted no refill is started. fault_v clears on FLUSH or when a miss to a different line starts.
- FLUSH: clears all valid bits and fault_v at the next edge.
  - FLUSH during REQ/FILL: the fill continues but sets poison, so the completed line is not marked valid. Poison clears on return to IDLE.
  - FLUSH in IDLE suppresses miss start that cycle.
- MEM_RVALID outside FILL is ignored.

## Timing
- Reset values: state=IDLE, all valid=0, fault_v=0, poison=0, beat=0, MEM_REQ=0, MEM_ADDR=0. Consequently icache_r=0 and icache_fault=0.
- Hit: zero latency, combinational from PC.
- Miss, zero-wait memory (GNT in first REQ cycle, RVALID every cycle): miss seen in cycle 0, MEM_REQ high in cycle 1, beats in cycles 2..1+WORDS_PER_LINE, icache_r=1 in cycle 2+WORDS_PER_LINE (default 6).
- MEM_REQ/MEM_ADDR are held stable until the GNT edge. MEM_REQ falls the cycle after GNT.
- RVALID gaps are allowed; the beat counter simply holds.
- RESET asserted mid-fill: immediate return to reset values. Beats from the old burst arriving after reset release are ignored, since the state is IDLE.

## Test plan
- Cold miss: reset, PC=0x0, mem returns 0x00000013,0x00100093,0x00200113,0x00300193 with zero wait → MEM_REQ at cycle 1 with MEM_ADDR=0x0; icache_r=1 at cycle 6; PC=0x8 gives instruction=0x00200113 with no new MEM_REQ.
- Conflict: after line 0x0 is filled, PC=0x400 misses (same index 0) and fills; returning to PC=0x0 misses again with MEM_ADDR=0x0.
- Flush mid-fill: FLUSH pulse on the second beat of a fill of 0x40 → fill completes, state IDLE, icache_r stays 0 at PC=0x40 and a new MEM_REQ is issued.
- Bus error: MEM_ERR on beat 1 of a fill of 0x80 → icache_fault=1 and icache_r=0 for PC=0x84 with no further MEM_REQ. PC=0xC0 clears fault_v and starts a fill. A later FLUSH also clears the fault.
- Stalled handshake: MEM_GNT delayed 3 cycles, RVALID every other cycle, PC changed during fill → MEM_ADDR stable through GNT, the originally captured line is filled, and the new PC misses afterward.
- Async reset during FILL after 2 beats → outputs take reset values immediately; stray beats are ignored; the next access to the same PC misses and refills fully.
